alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station in front of the integer ALU.
- Accepts decoded ALU/branch/JAL/JALR ops from dispatch and holds them until both operands are valid.
- Snoops two CDBs (ALU CDB and LSB CDB) to wake up waiting operands.
- Issues one ready op to the ALU through the ALU's issue interface (ready/rob_id/type/op/v1/v2), honouring the ALU's registered result timing.

Parameters:
- RS_SIZE, 8: number of entries (power of two, 2..16).
- ROB_W, 5: ROB tag width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  ready; when low, all state frozen.
- _clear  in  1  flush (mispredict); synchronous.
- _disp_valid  in  1  dispatch an op this cycle.
- _disp_rob_id  in  ROB_W  destination ROB tag.
- _disp_type  in  7  opcode (0110011/0010011/1100011/1101111/1100111).
- _disp_op  in  4  ALU op code.
- _disp_v1, _disp_v2  in  32 each  operand values.
- _disp_q1_busy, _disp_q2_busy  in  1 each  operand waits on a tag.
- _disp_q1, _disp_q2  in  ROB_W each  producer tags.
- _rs_full  out  1  no free entry; dispatch must not assert _disp_valid.
- _alu_cdb_ready  in  1  ALU CDB valid.
- _alu_cdb_rob_id  in  ROB_W  ALU CDB tag.
- _alu_cdb_value  in  32  ALU CDB value.
- _lsb_cdb_ready  in  1  LSB CDB valid.
- _lsb_cdb_rob_id  in  ROB_W  LSB CDB tag.
- _lsb_cdb_value  in  32  LSB CDB value.
- _alu_ready  out  1  issue strobe to ALU (registered).
- _alu_rob_id  out  ROB_W  issued tag (registered).
- _alu_type  out  7  issued opcode (registered).
- _alu_op  out  4  issued op (registered).
- _alu_v1, _alu_v2  out  32 each  issued operands (registered).

Behaviour:
- Reset (rst_in=0, async): all entries invalid, _alu_ready=0, _alu_rob_id/_alu_type/_alu_op/_alu_v1/_alu_v2=0, state=IDLE.
- rdy_in=0: no register changes, and dispatch is ignored. The dispatcher also sees a stall.
- _clear=1 (with rdy_in=1): all entries invalid and _alu_ready<=0. Dispatch that cycle is discarded. _clear takes priority over everything.
- Entry fields: busy, rob_id, type, op, v1, v2, q1_busy, q1, q2_busy, q2.
- Allocation: lowest-index free entry, computed from current-cycle state. An entry freed by issue this cycle is not reusable until next cycle.
- _rs_full: combinational; 1 iff all entries busy.
- Wakeup: each cycle, every busy entry with qN_busy and qN==cdb tag (either CDB valid) captures the value and clears qN_busy. If both CDBs match the same tag, the ALU CDB wins.
- Dispatch bypass: if an incoming operand's tag matches a valid CDB in the dispatch cycle, the entry is written with the value and q_busy=0.
- Ready entry: busy && !q1_busy && !q2_busy, evaluated on registered state. Wakeup makes an entry eligible the next cycle.
- Issue state machine, required because the ALU computes its result from _alu_v* one cycle after _alu_ready:
  - IDLE: if any ready entry, select one, load the output registers, _alu_ready<=1, free the entry, go to HOLD. Otherwise stay.
  - HOLD: _alu_ready<=0, output registers held unchanged (ALU result cycle), go to IDLE.
  - Maximum issue rate is one op per 2 cycles. Issue-to-CDB latency is 2 cycles from the select edge.
- Selection (default): lowest-index ready entry.
- Simultaneous dispatch + issue + wakeup in one cycle: all are honoured independently.

Optional Feature:
- RS_AGE_PICK_EN defined:
  - Each entry keeps a 4-bit age counter: 0 on allocate, +1 per non-stalled cycle while busy, saturating at 15.
  - Selection picks the ready entry with the largest age; ties go to the lowest index.
- Undefined: no age counters; lowest-index selection.

Test Plan:
- Reset then dispatch ADD (type 0110011, op 0, v1=5, v2=7, no tags, rob 3) -> _alu_ready=1 with rob 3, v1=5, v2=7 one cycle after dispatch edge; next cycle _alu_ready=0 with operands held; ALU CDB then shows 12 for rob 3.
- Dispatch op waiting on q1=9; LSB CDB broadcasts rob 9, value 0x100 two cycles later -> issue the cycle after broadcast with v1=0x100.
- Dispatch with q2=4 in the same cycle the ALU CDB broadcasts rob 4, value 0xDEAD -> entry captured ready (v2=0xDEAD); issues next cycle.
- Fill 8 entries all waiting on tag 1 -> _rs_full=1. Broadcast tag 1 -> ops issue on alternating cycles, _alu_ready pattern 1,0,1,0…; _rs_full drops after the first issue.
- 3 ready entries, _clear asserted during HOLD -> next cycle no busy entries, _alu_ready=0, _rs_full=0; no further issues.
- rst_in pulsed low mid-HOLD (asynchronously, between edges) -> outputs 0 immediately. rdy_in low 3 cycles with a ready entry -> no issue until rdy_in returns.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU, snooping the ALU and LSB CDBs.
// Define RS_AGE_PICK_EN to issue the oldest ready entry instead of the lowest-index one.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _disp_valid,
  input  logic [ROB_W-1:0] _disp_rob_id,
  input  logic [6:0]       _disp_type,
  input  logic [3:0]       _disp_op,
  input  logic [31:0]      _disp_v1,
  input  logic [31:0]      _disp_v2,
  input  logic             _disp_q1_busy,
  input  logic             _disp_q2_busy,
  input  logic [ROB_W-1:0] _disp_q1,
  input  logic [ROB_W-1:0] _disp_q2,
  output logic             _rs_full,
  input  logic             _alu_cdb_ready,
  input  logic [ROB_W-1:0] _alu_cdb_rob_id,
  input  logic [31:0]      _alu_cdb_value,
  input  logic             _lsb_cdb_ready,
  input  logic [ROB_W-1:0] _lsb_cdb_rob_id,
  input  logic [31:0]      _lsb_cdb_value,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [6:0]       _alu_type,
  output logic [3:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] q1_busy;
  logic [RS_SIZE-1:0] q2_busy;
  logic [ROB_W-1:0]   rob_id [RS_SIZE];
  logic [6:0]         typ    [RS_SIZE];
  logic [3:0]         op     [RS_SIZE];
  logic [DATA_W-1:0]  v1     [RS_SIZE];
  logic [DATA_W-1:0]  v2     [RS_SIZE];
  logic [ROB_W-1:0]   q1     [RS_SIZE];
  logic [ROB_W-1:0]   q2     [RS_SIZE];

  // {still_waiting, value}: the ALU CDB is checked first so it wins a tag tie with the LSB CDB.
  function automatic logic [DATA_W:0] resolve(
    input logic              wait_q,
    input logic [ROB_W-1:0]  tag,
    input logic [DATA_W-1:0] val,
    input logic              a_rdy,
    input logic [ROB_W-1:0]  a_tag,
    input logic [DATA_W-1:0] a_val,
    input logic              l_rdy,
    input logic [ROB_W-1:0]  l_tag,
    input logic [DATA_W-1:0] l_val
  );
    if (wait_q && a_rdy && (a_tag == tag)) return {1'b0, a_val};
    if (wait_q && l_rdy && (l_tag == tag)) return {1'b0, l_val};
    return {wait_q, val};
  endfunction

  logic [DATA_W:0]    d1, d2;
  logic [DATA_W:0]    wk1 [RS_SIZE];
  logic [DATA_W:0]    wk2 [RS_SIZE];
  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_ready;
  logic               alloc;
  logic               issue;

  assign d1 = resolve(_disp_q1_busy, _disp_q1, _disp_v1,
                      _alu_cdb_ready, _alu_cdb_rob_id, _alu_cdb_value,
                      _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value);
  assign d2 = resolve(_disp_q2_busy, _disp_q2, _disp_v2,
                      _alu_cdb_ready, _alu_cdb_rob_id, _alu_cdb_value,
                      _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value);

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wk1[i] = resolve(busy[i] && q1_busy[i], q1[i], v1[i],
                       _alu_cdb_ready, _alu_cdb_rob_id, _alu_cdb_value,
                       _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value);
      wk2[i] = resolve(busy[i] && q2_busy[i], q2[i], v2[i],
                       _alu_cdb_ready, _alu_cdb_rob_id, _alu_cdb_value,
                       _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value);
    end
  end

  assign ready_vec = busy & ~q1_busy & ~q2_busy;
  assign any_ready = |ready_vec;
  assign _rs_full  = &busy;
  assign alloc     = rdy_in && !_clear && _disp_valid && !_rs_full;
  assign issue     = rdy_in && !_clear && (state == IDLE) && any_ready;

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_PICK_EN
  logic [3:0] age [RS_SIZE];
  logic [3:0] best_age;
  logic       found;

  function automatic logic [3:0] sat_inc4(input logic [3:0] a);
    return (a == 4'hF) ? a : a + 4'd1;
  endfunction

  always_comb begin
    sel_idx  = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && (!found || (age[i] > best_age))) begin
        found    = 1'b1;
        best_age = age[i];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (alloc && (free_idx == IDX_W'(i))) age[i] <= '0;
        else if (busy[i])                     age[i] <= sat_inc4(age[i]);
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // Control state: entry occupancy, operand wait flags, issue FSM and the ALU-facing registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      q1_busy     <= '0;
      q2_busy     <= '0;
      state       <= IDLE;
      _alu_ready  <= 1'b0;
      _alu_rob_id <= '0;
      _alu_type   <= '0;
      _alu_op     <= '0;
      _alu_v1     <= '0;
      _alu_v2     <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        busy       <= '0;
        _alu_ready <= 1'b0;
        state      <= IDLE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          q1_busy[i] <= wk1[i][DATA_W];
          q2_busy[i] <= wk2[i][DATA_W];
        end
        if (issue) busy[sel_idx] <= 1'b0;
        if (alloc) begin
          busy[free_idx]    <= 1'b1;
          q1_busy[free_idx] <= d1[DATA_W];
          q2_busy[free_idx] <= d2[DATA_W];
        end
        case (state)
          IDLE: begin
            if (any_ready) begin
              _alu_ready  <= 1'b1;
              _alu_rob_id <= rob_id[sel_idx];
              _alu_type   <= typ[sel_idx];
              _alu_op     <= op[sel_idx];
              _alu_v1     <= v1[sel_idx];
              _alu_v2     <= v2[sel_idx];
              state       <= HOLD;
            end
          end
          HOLD: begin
            _alu_ready <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Entry payload: only meaningful while the matching busy bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        v1[i] <= wk1[i][DATA_W-1:0];
        v2[i] <= wk2[i][DATA_W-1:0];
      end
      if (alloc) begin
        rob_id[free_idx] <= _disp_rob_id;
        typ[free_idx]    <= _disp_type;
        op[free_idx]     <= _disp_op;
        v1[free_idx]     <= d1[DATA_W-1:0];
        v2[free_idx]     <= d2[DATA_W-1:0];
        q1[free_idx]     <= _disp_q1;
        q2[free_idx]     <= _disp_q2;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/CDB vectors, a one-op ALU model closing the CDB loop.
module tb_alu_rs;

  localparam logic [6:0] T_ADD  = 7'b0110011;
  localparam logic [6:0] T_ADDI = 7'b0010011;
  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;

  logic        clk_in, rst_in, rdy_in, clear;
  logic        disp_valid;
  logic [4:0]  disp_rob_id;
  logic [6:0]  disp_type;
  logic [3:0]  disp_op;
  logic [31:0] disp_v1, disp_v2;
  logic        disp_q1_busy, disp_q2_busy;
  logic [4:0]  disp_q1, disp_q2;
  logic        rs_full;
  logic        alu_cdb_ready;
  logic [4:0]  alu_cdb_rob_id;
  logic [31:0] alu_cdb_value;
  logic        lsb_cdb_ready;
  logic [4:0]  lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_value;
  logic        alu_ready;
  logic [4:0]  alu_rob_id;
  logic [6:0]  alu_type;
  logic [3:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;

  logic        man_rdy;
  logic [4:0]  man_rob;
  logic [31:0] man_val;
  logic        mdl_pend, mdl_rdy;
  logic [4:0]  mdl_rob, mdl_rob_q;
  logic [31:0] mdl_val;

  alu_rs #(.RS_SIZE(8), .ROB_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clear),
    ._disp_valid(disp_valid), ._disp_rob_id(disp_rob_id), ._disp_type(disp_type),
    ._disp_op(disp_op), ._disp_v1(disp_v1), ._disp_v2(disp_v2),
    ._disp_q1_busy(disp_q1_busy), ._disp_q2_busy(disp_q2_busy),
    ._disp_q1(disp_q1), ._disp_q2(disp_q2), ._rs_full(rs_full),
    ._alu_cdb_ready(alu_cdb_ready), ._alu_cdb_rob_id(alu_cdb_rob_id), ._alu_cdb_value(alu_cdb_value),
    ._lsb_cdb_ready(lsb_cdb_ready), ._lsb_cdb_rob_id(lsb_cdb_rob_id), ._lsb_cdb_value(lsb_cdb_value),
    ._alu_ready(alu_ready), ._alu_rob_id(alu_rob_id), ._alu_type(alu_type),
    ._alu_op(alu_op), ._alu_v1(alu_v1), ._alu_v2(alu_v2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // ALU stand-in: latches the strobe, adds the held operands one cycle later, broadcasts next edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mdl_pend  <= 1'b0;
      mdl_rdy   <= 1'b0;
      mdl_rob   <= '0;
      mdl_rob_q <= '0;
      mdl_val   <= '0;
    end else begin
      mdl_pend <= alu_ready;
      mdl_rob  <= alu_rob_id;
      mdl_rdy  <= mdl_pend;
      if (mdl_pend) begin
        mdl_val   <= alu_v1 + alu_v2;
        mdl_rob_q <= mdl_rob;
      end
    end
  end

  assign alu_cdb_ready  = mdl_rdy | man_rdy;
  assign alu_cdb_rob_id = mdl_rdy ? mdl_rob_q : man_rob;
  assign alu_cdb_value  = mdl_rdy ? mdl_val : man_val;

  typedef struct {
    logic [4:0]  rob;
    logic [6:0]  typ;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] val;
    int          cyc;
  } cdb_t;

  iss_t iq[$];
  cdb_t cq[$];
  iss_t e, he;
  cdb_t ce;
  logic hold_chk = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [4:0] rob, input logic [6:0] typ, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input int at,
                              input logic with_cdb, input logic [31:0] res);
    iss_t x;
    cdb_t y;
    x.rob = rob; x.typ = typ; x.op = op; x.v1 = a; x.v2 = b; x.cyc = at;
    iq.push_back(x);
    if (with_cdb) begin
      y.rob = rob; y.val = res; y.cyc = at + 2;
      cq.push_back(y);
    end
  endtask

  // Monitor: issue strobes, the held cycle after each strobe, and ALU results on the CDB.
  always @(negedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_chk = 1'b0;
    end else if (!clk_in) begin
      if (hold_chk) begin
        nchk++;
        if (alu_ready || alu_rob_id !== he.rob || alu_type !== he.typ || alu_op !== he.op ||
            alu_v1 !== he.v1 || alu_v2 !== he.v2) begin
          nerr++;
          $display("FAIL hold cyc %0d: rdy=%0b rob=%0d v1=%0h v2=%0h expected rdy=0 rob=%0d v1=%0h v2=%0h",
                   cyc, alu_ready, alu_rob_id, alu_v1, alu_v2, he.rob, he.v1, he.v2);
        end
        hold_chk = 1'b0;
      end
      if (alu_ready) begin
        nchk++;
        if (iq.size() == 0) begin
          nerr++;
          $display("FAIL issue cyc %0d: unexpected issue rob=%0d expected none", cyc, alu_rob_id);
        end else begin
          e = iq.pop_front();
          if (alu_rob_id !== e.rob || alu_type !== e.typ || alu_op !== e.op ||
              alu_v1 !== e.v1 || alu_v2 !== e.v2 || cyc != e.cyc) begin
            nerr++;
            $display("FAIL issue: got rob=%0d type=%b op=%0d v1=%0h v2=%0h cyc=%0d expected rob=%0d type=%b op=%0d v1=%0h v2=%0h cyc=%0d",
                     alu_rob_id, alu_type, alu_op, alu_v1, alu_v2, cyc, e.rob, e.typ, e.op, e.v1, e.v2, e.cyc);
          end
          he = e;
          hold_chk = 1'b1;
        end
      end
      if (mdl_rdy) begin
        nchk++;
        if (cq.size() == 0) begin
          nerr++;
          $display("FAIL cdb cyc %0d: unexpected result rob=%0d expected none", cyc, mdl_rob_q);
        end else begin
          ce = cq.pop_front();
          if (mdl_rob_q !== ce.rob || mdl_val !== ce.val || cyc != ce.cyc) begin
            nerr++;
            $display("FAIL cdb: got rob=%0d val=%0h cyc=%0d expected rob=%0d val=%0h cyc=%0d",
                     mdl_rob_q, mdl_val, cyc, ce.rob, ce.val, ce.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_disp(input logic [4:0] rob, input logic [6:0] typ, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic b1, input logic [4:0] t1, input logic b2, input logic [4:0] t2);
    disp_valid = 1'b1; disp_rob_id = rob; disp_type = typ; disp_op = op;
    disp_v1 = a; disp_v2 = b;
    disp_q1_busy = b1; disp_q1 = t1; disp_q2_busy = b2; disp_q2 = t2;
  endtask

  task automatic dispatch(input logic [4:0] rob, input logic [6:0] typ, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic b1, input logic [4:0] t1, input logic b2, input logic [4:0] t2);
    set_disp(rob, typ, op, a, b, b1, t1, b2, t2);
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic lsb_bcast(input logic [4:0] rob, input logic [31:0] val);
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = rob; lsb_cdb_value = val;
    tick();
    lsb_cdb_ready = 1'b0;
  endtask

  int c;

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    disp_valid = 1'b0; disp_rob_id = '0; disp_type = '0; disp_op = '0;
    disp_v1 = '0; disp_v2 = '0; disp_q1_busy = 1'b0; disp_q2_busy = 1'b0;
    disp_q1 = '0; disp_q2 = '0;
    lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    man_rdy = 1'b0; man_rob = '0; man_val = '0;

    repeat (2) tick();
    chk("rst_ready", 64'(alu_ready), 64'd0);
    chk("rst_rob_type_op", 64'({alu_rob_id, alu_type, alu_op}), 64'd0);
    chk("rst_v1", 64'(alu_v1), 64'd0);
    chk("rst_v2", 64'(alu_v2), 64'd0);
    chk("rst_full", 64'(rs_full), 64'd0);
    rst_in = 1'b1;
    repeat (2) tick();

    // ADD 5+7, no tags: issue one cycle after the dispatch edge, result 12 on the CDB
    c = cyc;
    expect_issue(5'd3, T_ADD, 4'd0, 32'd5, 32'd7, c + 2, 1'b1, 32'd12);
    dispatch(5'd3, T_ADD, 4'd0, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (6) tick();

    // q1 waits on tag 9; LSB CDB supplies 0x100 two cycles later
    c = cyc;
    expect_issue(5'd5, T_ADDI, 4'd0, 32'h100, 32'h20, c + 4, 1'b1, 32'h120);
    dispatch(5'd5, T_ADDI, 4'd0, 32'hFFFF_FFFF, 32'h20, 1'b1, 5'd9, 1'b0, 5'd0);
    tick();
    lsb_bcast(5'd9, 32'h100);
    repeat (6) tick();

    // dispatch-cycle bypass from the ALU CDB for q2 = 4
    c = cyc;
    expect_issue(5'd6, T_BR, 4'd2, 32'h11, 32'hDEAD, c + 2, 1'b1, 32'hDEBE);
    man_rdy = 1'b1; man_rob = 5'd4; man_val = 32'hDEAD;
    dispatch(5'd6, T_BR, 4'd2, 32'h11, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4);
    man_rdy = 1'b0;
    repeat (6) tick();

    // both CDBs carry tag 20 in one cycle: the ALU CDB value wins
    c = cyc;
    expect_issue(5'd7, T_JAL, 4'd0, 32'hA, 32'h1, c + 3, 1'b1, 32'hB);
    dispatch(5'd7, T_JAL, 4'd0, 32'h0, 32'h1, 1'b1, 5'd20, 1'b0, 5'd0);
    man_rdy = 1'b1; man_rob = 5'd20; man_val = 32'hA;
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 5'd20; lsb_cdb_value = 32'h55;
    tick();
    man_rdy = 1'b0; lsb_cdb_ready = 1'b0;
    repeat (6) tick();

    // fill all 8 entries on tag 1, then wake them together
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      expect_issue(5'(10 + i), (i % 2 == 1) ? T_JALR : T_ADD, 4'(i), 32'h1000, 32'(i),
                   c + 10 + 2 * i, 1'b1, 32'h1000 + 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("full_before_last", 64'(rs_full), 64'd0);
      dispatch(5'(10 + i), (i % 2 == 1) ? T_JALR : T_ADD, 4'(i), 32'h0, 32'(i), 1'b1, 5'd1, 1'b0, 5'd0);
    end
    chk("full_8", 64'(rs_full), 64'd1);
    lsb_bcast(5'd1, 32'h1000);
    chk("full_after_wakeup", 64'(rs_full), 64'd1);
    tick();
    chk("full_after_first_issue", 64'(rs_full), 64'd0);
    repeat (20) tick();

    // three ready entries, flush in the HOLD cycle; a same-cycle dispatch is dropped
    c = cyc;
    expect_issue(5'd21, T_ADD, 4'd0, 32'd1, 32'h200, c + 5, 1'b1, 32'h201);
    for (int i = 0; i < 3; i++) begin
      dispatch(5'(21 + i), T_ADD, 4'd0, 32'(i + 1), 32'h0, 1'b0, 5'd0, 1'b1, 5'd2);
    end
    lsb_bcast(5'd2, 32'h200);
    tick();
    clear = 1'b1;
    set_disp(5'd24, T_ADD, 4'd0, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    clear = 1'b0; disp_valid = 1'b0;
    chk("clear_ready", 64'(alu_ready), 64'd0);
    chk("clear_full", 64'(rs_full), 64'd0);
    repeat (8) tick();

    // asynchronous reset between edges while in HOLD
    c = cyc;
    expect_issue(5'd25, T_ADDI, 4'd0, 32'd1, 32'd2, c + 2, 1'b0, 32'd0);
    dispatch(5'd25, T_ADDI, 4'd0, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    #1;
    chk("async_rst_ready", 64'(alu_ready), 64'd0);
    chk("async_rst_rob", 64'(alu_rob_id), 64'd0);
    chk("async_rst_v1", 64'(alu_v1), 64'd0);
    chk("async_rst_v2", 64'(alu_v2), 64'd0);
    #1 rst_in = 1'b1;
    repeat (4) tick();

    // rdy_in low for 3 cycles with a ready entry; a stalled dispatch is ignored
    c = cyc;
    expect_issue(5'd26, T_JALR, 4'd3, 32'h30, 32'h40, c + 5, 1'b1, 32'h70);
    dispatch(5'd26, T_JALR, 4'd3, 32'h30, 32'h40, 1'b0, 5'd0, 1'b0, 5'd0);
    rdy_in = 1'b0;
    set_disp(5'd27, T_ADD, 4'd0, 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_issue", 64'(alu_ready), 64'd0);
    end
    rdy_in = 1'b1; disp_valid = 1'b0;
    repeat (8) tick();

    chk("issue_queue_drained", 64'(iq.size()), 64'd0);
    chk("cdb_queue_drained", 64'(cq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
